// File: rtl/fir_pkg.sv
// Shared types and constants for the 4-tap FIR sequencing controller.
package fir_pkg;

  localparam int FIR_REG_AW = 4;
  localparam int FIR_OP_W   = 3;

  typedef enum logic [4:0] {
    IDLE, EIDLE, COEFF, STORE, ZERO,
    SHIFT1, SHIFT2, SHIFT3, SHIFT4,
    MUL1, ADD1, MUL2, SUB2, MUL3, ADD3, MUL4, SUB4
  } fir_ctrl_state;

  localparam logic [FIR_OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [FIR_OP_W-1:0] OP_COPY  = 3'd1;
  localparam logic [FIR_OP_W-1:0] OP_LOAD1 = 3'd2;
  localparam logic [FIR_OP_W-1:0] OP_LOAD2 = 3'd3;
  localparam logic [FIR_OP_W-1:0] OP_ADD   = 3'd4;
  localparam logic [FIR_OP_W-1:0] OP_SUB   = 3'd5;
  localparam logic [FIR_OP_W-1:0] OP_MUL   = 3'd6;

  localparam logic [FIR_REG_AW-1:0] R_ACC = 4'd0;
  localparam logic [FIR_REG_AW-1:0] R_S1  = 4'd1;
  localparam logic [FIR_REG_AW-1:0] R_S2  = 4'd2;
  localparam logic [FIR_REG_AW-1:0] R_S3  = 4'd3;
  localparam logic [FIR_REG_AW-1:0] R_S4  = 4'd4;
  localparam logic [FIR_REG_AW-1:0] R_NEW = 4'd5;
  localparam logic [FIR_REG_AW-1:0] R_F0  = 4'd6;
  localparam logic [FIR_REG_AW-1:0] R_F1  = 4'd7;
  localparam logic [FIR_REG_AW-1:0] R_F2  = 4'd8;
  localparam logic [FIR_REG_AW-1:0] R_F3  = 4'd9;
  localparam logic [FIR_REG_AW-1:0] R_TMP = 4'd10;

  // Coefficient register that holds coefficient index num.
  function automatic logic [FIR_REG_AW-1:0] coeff_reg(input logic [1:0] num);
    return R_F0 + {2'b00, num};
  endfunction

endpackage

// File: rtl/fir_controller.sv
// Sequencer for the 4-tap FIR datapath: one register-file/ALU micro-op per cycle.
//
//  state   | meaning
//  IDLE    | waiting for a sample or coefficient strobe
//  EIDLE   | waiting after an error (overflow / sample without valid coeffs)
//  COEFF   | LOAD2 of the latched coefficient index into R6..R9
//  STORE   | LOAD1 of the new sample into R5, cnt_up pulse
//  ZERO    | clear accumulator R0
//  SHIFT1-4| shift sample history R4<-R3<-R2<-R1<-R5
//  MULn    | R10 = history(n) * F(n-1)
//  ADD/SUB | accumulate R10 into R0 (alternating sign), overflow aborts
module fir_controller
  import fir_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              data_ready,
  input  logic              load_coeff,
  input  logic [1:0]        coefficient_num,
  input  logic              clear_coeff,
  input  logic              overflow,
  output logic              modwait,
  output logic              cnt_up,
  output logic [OP_W-1:0]   op,
  output logic [REG_AW-1:0] src1,
  output logic [REG_AW-1:0] src2,
  output logic [REG_AW-1:0] dest,
  output logic              err
);

  fir_ctrl_state state_q, state_d;
  logic       samp_pend_q, samp_pend_d;
  logic       coef_pend_q, coef_pend_d;
  logic [1:0] coef_num_q, coef_num_d;
  logic       coeff_valid_q, coeff_valid_d;
  logic       err_q, err_d;
  logic       modwait_q, modwait_d;

  logic busy, samp_take, samp_drop, ovf_abort;
  logic [FIR_OP_W-1:0]   op_c;
  logic [FIR_REG_AW-1:0] src1_c, src2_c, dest_c;

  // State, pending flags and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      samp_pend_q   <= 1'b0;
      coef_pend_q   <= 1'b0;
      coef_num_q    <= 2'd0;
      coeff_valid_q <= 1'b0;
      err_q         <= 1'b0;
      modwait_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_pend_q   <= samp_pend_d;
      coef_pend_q   <= coef_pend_d;
      coef_num_q    <= coef_num_d;
      coeff_valid_q <= coeff_valid_d;
      err_q         <= err_d;
      modwait_q     <= modwait_d;
    end
  end

  // Next-state sequencing plus pending-strobe, coeff-valid and error bookkeeping.
  always_comb begin
    state_d   = state_q;
    samp_take = 1'b0;
    busy      = (state_q != IDLE) && (state_q != EIDLE);
    ovf_abort = overflow && ((state_q == ADD1) || (state_q == SUB2) ||
                             (state_q == ADD3) || (state_q == SUB4));
    case (state_q)
      IDLE, EIDLE: begin
        // A coefficient left pending by an aborted sequence is served right away.
        if (load_coeff || coef_pend_q) state_d = COEFF;
        else if (data_ready)           state_d = coeff_valid_q ? STORE : EIDLE;
      end
      COEFF: begin
        if (coef_pend_q) state_d = COEFF;
        else if (samp_pend_q) begin
          samp_take = 1'b1;
          state_d   = coeff_valid_q ? STORE : EIDLE;
        end else state_d = IDLE;
      end
      STORE:  state_d = ZERO;
      ZERO:   state_d = SHIFT1;
      SHIFT1: state_d = SHIFT2;
      SHIFT2: state_d = SHIFT3;
      SHIFT3: state_d = SHIFT4;
      SHIFT4: state_d = MUL1;
      MUL1:   state_d = ADD1;
      ADD1:   state_d = overflow ? EIDLE : MUL2;
      MUL2:   state_d = SUB2;
      SUB2:   state_d = overflow ? EIDLE : MUL3;
      MUL3:   state_d = ADD3;
      ADD3:   state_d = overflow ? EIDLE : MUL4;
      MUL4:   state_d = SUB4;
      SUB4: begin
        if (overflow)         state_d = EIDLE;
        else if (coef_pend_q) state_d = COEFF;
        else if (samp_pend_q) begin
          samp_take = 1'b1;
          state_d   = coeff_valid_q ? STORE : EIDLE;
        end else state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    samp_pend_d = samp_pend_q && !samp_take;
    samp_drop   = 1'b0;
    // A sample arriving while busy (or alongside a coeff strobe in IDLE) waits one deep.
    if (data_ready && (busy || (state_d == COEFF))) begin
      if (samp_pend_d) samp_drop   = 1'b1;
      else             samp_pend_d = 1'b1;
    end
    if (ovf_abort) samp_pend_d = 1'b0;

    coef_pend_d = coef_pend_q;
    if (state_d == COEFF)      coef_pend_d = 1'b0;
    if (load_coeff && busy)    coef_pend_d = 1'b1;
    coef_num_d = load_coeff ? coefficient_num : coef_num_q;

    coeff_valid_d = coeff_valid_q;
    if (load_coeff && (coefficient_num == 2'd0)) coeff_valid_d = 1'b0;
    if (clear_coeff)                             coeff_valid_d = 1'b1;

    err_d = err_q;
    if ((state_d == STORE) || (state_d == COEFF)) err_d = 1'b0;
    if (samp_drop || (state_d == EIDLE))          err_d = 1'b1;

    modwait_d = (state_d != IDLE) && (state_d != EIDLE);
  end

  // Micro-op decode from the current state.
  always_comb begin
    op_c   = OP_NOP;
    src1_c = R_ACC;
    src2_c = R_ACC;
    dest_c = R_ACC;
    case (state_q)
      COEFF:  begin op_c = OP_LOAD2; dest_c = coeff_reg(coef_num_q); end
      STORE:  begin op_c = OP_LOAD1; dest_c = R_NEW; end
      ZERO:   begin op_c = OP_SUB; src1_c = R_ACC; src2_c = R_ACC; dest_c = R_ACC; end
      SHIFT1: begin op_c = OP_COPY; src1_c = R_S3;  dest_c = R_S4; end
      SHIFT2: begin op_c = OP_COPY; src1_c = R_S2;  dest_c = R_S3; end
      SHIFT3: begin op_c = OP_COPY; src1_c = R_S1;  dest_c = R_S2; end
      SHIFT4: begin op_c = OP_COPY; src1_c = R_NEW; dest_c = R_S1; end
      MUL1:   begin op_c = OP_MUL; src1_c = R_S1; src2_c = R_F0; dest_c = R_TMP; end
      MUL2:   begin op_c = OP_MUL; src1_c = R_S2; src2_c = R_F1; dest_c = R_TMP; end
      MUL3:   begin op_c = OP_MUL; src1_c = R_S3; src2_c = R_F2; dest_c = R_TMP; end
      MUL4:   begin op_c = OP_MUL; src1_c = R_S4; src2_c = R_F3; dest_c = R_TMP; end
      ADD1, ADD3: begin op_c = OP_ADD; src1_c = R_ACC; src2_c = R_TMP; dest_c = R_ACC; end
      SUB2, SUB4: begin op_c = OP_SUB; src1_c = R_ACC; src2_c = R_TMP; dest_c = R_ACC; end
      default: op_c = OP_NOP;
    endcase
  end

  assign op      = OP_W'(op_c);
  assign src1    = REG_AW'(src1_c);
  assign src2    = REG_AW'(src2_c);
  assign dest    = REG_AW'(dest_c);
  assign cnt_up  = (state_q == STORE);
  assign err     = err_q;
  assign modwait = modwait_q;

endmodule

// File: tb/tb_fir_controller.sv
// Directed bench for fir_controller: expected micro-ops are queued by the stimulus
// and popped by a negedge monitor whenever the controller issues an op.
module tb_fir_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       data_ready = 1'b0;
  logic       load_coeff = 1'b0;
  logic [1:0] coefficient_num = 2'd0;
  logic       clear_coeff = 1'b0;
  logic       overflow = 1'b0;
  logic       modwait, cnt_up, err;
  logic [2:0] op;
  logic [3:0] src1, src2, dest;

  typedef struct packed {
    logic [2:0] op;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] d;
    logic       cu;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  fir_controller #(.REG_AW(4), .OP_W(3)) dut (
    .clk(clk), .rst(rst), .data_ready(data_ready), .load_coeff(load_coeff),
    .coefficient_num(coefficient_num), .clear_coeff(clear_coeff), .overflow(overflow),
    .modwait(modwait), .cnt_up(cnt_up), .op(op), .src1(src1), .src2(src2),
    .dest(dest), .err(err)
  );

  always #5 clk = ~clk;

  // Hand-computed micro-op trace of one sample sequence.
  function automatic exp_t seq_item(input int i);
    exp_t e;
    case (i)
      0:  e = '{3'd2, 4'd0, 4'd0, 4'd5,  1'b1};
      1:  e = '{3'd5, 4'd0, 4'd0, 4'd0,  1'b0};
      2:  e = '{3'd1, 4'd3, 4'd0, 4'd4,  1'b0};
      3:  e = '{3'd1, 4'd2, 4'd0, 4'd3,  1'b0};
      4:  e = '{3'd1, 4'd1, 4'd0, 4'd2,  1'b0};
      5:  e = '{3'd1, 4'd5, 4'd0, 4'd1,  1'b0};
      6:  e = '{3'd6, 4'd1, 4'd6, 4'd10, 1'b0};
      7:  e = '{3'd4, 4'd0, 4'd10, 4'd0, 1'b0};
      8:  e = '{3'd6, 4'd2, 4'd7, 4'd10, 1'b0};
      9:  e = '{3'd5, 4'd0, 4'd10, 4'd0, 1'b0};
      10: e = '{3'd6, 4'd3, 4'd8, 4'd10, 1'b0};
      11: e = '{3'd4, 4'd0, 4'd10, 4'd0, 1'b0};
      12: e = '{3'd6, 4'd4, 4'd9, 4'd10, 1'b0};
      default: e = '{3'd5, 4'd0, 4'd10, 4'd0, 1'b0};
    endcase
    return e;
  endfunction

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) sb.push_back(seq_item(i));
  endtask

  task automatic push_coeff(input int d);
    exp_t e;
    e = '{3'd3, 4'd0, 4'd0, 4'(d), 1'b0};
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max_cycles);
    int n;
    n = 0;
    while (modwait !== 1'b0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("wait_idle", int'(modwait), 0);
  endtask

  // Monitor: every issued op must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t got, e;
    if (!rst && (op != 3'd0 || cnt_up)) begin
      got = '{op, src1, src2, dest, cnt_up};
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL op_unexpected: got op=%0d s1=%0d s2=%0d d=%0d cu=%0d expected none",
                 op, src1, src2, dest, cnt_up);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          bad++;
          $display("FAIL op_trace: got op=%0d s1=%0d s2=%0d d=%0d cu=%0d expected op=%0d s1=%0d s2=%0d d=%0d cu=%0d",
                   got.op, got.s1, got.s2, got.d, got.cu, e.op, e.s1, e.s2, e.d, e.cu);
        end
      end
    end
  end

  initial begin
    // Reset values
    step(); step();
    chk("rst_modwait", int'(modwait), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_cnt_up", int'(cnt_up), 0);
    chk("rst_regs", int'({src1, src2, dest}), 0);
    rst = 1'b0;
    step();

    // Sample with no coefficients loaded -> EIDLE, dropped
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("nocoef_err", int'(err), 1);
    chk("nocoef_modwait", int'(modwait), 0);
    chk("nocoef_cnt_up", int'(cnt_up), 0);
    chk("nocoef_op", int'(op), 0);
    step();
    chk("nocoef_cnt_up2", int'(cnt_up), 0);
    chk("nocoef_err2", int'(err), 1);

    // Coefficient load 0..3 then clear_coeff
    for (int n = 0; n < 4; n++) begin
      load_coeff = 1'b1;
      coefficient_num = 2'(n);
      push_coeff(6 + n);
      step();
      load_coeff = 1'b0;
      chk("coef_modwait_hi", int'(modwait), 1);
      chk("coef_err_clr", int'(err), 0);
      step();
      chk("coef_modwait_lo", int'(modwait), 0);
    end
    clear_coeff = 1'b1;
    step();
    clear_coeff = 1'b0;

    // Plain sample sequence: 14 ops, cnt_up only at t+1, IDLE at t+15
    data_ready = 1'b1;
    push_seq(14);
    step();
    data_ready = 1'b0;
    chk("s2_cnt_up", int'(cnt_up), 1);
    chk("s2_modwait_t1", int'(modwait), 1);
    for (int c = 2; c <= 14; c++) begin
      step();
      chk("s2_modwait", int'(modwait), 1);
      chk("s2_cnt_up_lo", int'(cnt_up), 0);
    end
    step();
    chk("s2_modwait_t15", int'(modwait), 0);
    chk("s2_op_t15", int'(op), 0);
    step();

    // Back-to-back: second sample at t+5, third at t+7 is dropped
    data_ready = 1'b1;
    push_seq(14);
    step();
    data_ready = 1'b0;
    repeat (4) step();
    data_ready = 1'b1;
    push_seq(14);
    step();
    data_ready = 1'b0;
    step();
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("s3_err_drop", int'(err), 1);
    for (int c = 9; c <= 28; c++) begin
      step();
      chk("s3_modwait", int'(modwait), 1);
      if (c == 15) begin
        chk("s3_store_cnt_up", int'(cnt_up), 1);
        chk("s3_err_clr", int'(err), 0);
      end
    end
    step();
    chk("s3_modwait_end", int'(modwait), 0);
    step();

    // Overflow during ADD3 (t+12) -> EIDLE at t+13
    data_ready = 1'b1;
    push_seq(12);
    step();
    data_ready = 1'b0;
    repeat (11) step();
    overflow = 1'b1;
    step();
    overflow = 1'b0;
    chk("ovf_err", int'(err), 1);
    chk("ovf_modwait", int'(modwait), 0);
    chk("ovf_op", int'(op), 0);
    step();
    data_ready = 1'b1;
    push_seq(14);
    step();
    data_ready = 1'b0;
    chk("ovf_recover_err", int'(err), 0);
    chk("ovf_recover_cnt_up", int'(cnt_up), 1);
    wait_idle(40);
    step();

    // load_coeff during MUL2 -> COEFF (dest 8) straight after SUB4
    data_ready = 1'b1;
    push_seq(14);
    push_coeff(8);
    step();
    data_ready = 1'b0;
    repeat (8) step();
    load_coeff = 1'b1;
    coefficient_num = 2'd2;
    step();
    load_coeff = 1'b0;
    coefficient_num = 2'd3;
    repeat (4) step();
    chk("s6_modwait_sub4", int'(modwait), 1);
    step();
    chk("s6_modwait_coeff", int'(modwait), 1);
    chk("s6_coeff_op", int'(op), 3);
    chk("s6_coeff_dest", int'(dest), 8);
    step();
    chk("s6_modwait_end", int'(modwait), 0);
    step();

    // rst asserted during MUL1
    data_ready = 1'b1;
    push_seq(6);
    step();
    data_ready = 1'b0;
    repeat (6) step();
    chk("s6_mul1_op", int'(op), 6);
    rst = 1'b1;
    #1;
    chk("rst_mid_op", int'(op), 0);
    chk("rst_mid_modwait", int'(modwait), 0);
    chk("rst_mid_regs", int'({src1, src2, dest}), 0);
    chk("rst_mid_err_cnt", int'({err, cnt_up}), 0);
    step();
    rst = 1'b0;
    step(); step();
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
